rv_multicycle_ctrl: RTL and testbench

- Multicycle RV32I control FSM. Sequences the shared datapath: PC, instruction register, immediate extender, ALU, register file and unified memory port.
- Drives ImmSrc to the immediate extender, ALU operand muxes, ALUControl, result mux and write enables.
- Talks to a variable-latency memory through a req/ready handshake, with a watchdog on memory waits.

---
 rtl/rv_ctrl_pkg.sv | 65 ++++++
 rtl/rv_multicycle_ctrl_alu_dec.sv | 37 +++
 rtl/rv_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control slice.
// Holds immediate-extender selects, base opcodes, ALU control codes,
// the ALU-decoder operation class and the controller state enum.
package rv_ctrl_pkg;

  // ImmSrc encodings, shared with the immediate extender
  localparam logic [2:0] IMM_R = 3'b000;
  localparam logic [2:0] IMM_I = 3'b001;
  localparam logic [2:0] IMM_S = 3'b010;
  localparam logic [2:0] IMM_B = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [2:0] IMM_J = 3'b101;

  // RV32I base opcodes (Instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  // Operation class handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD,
    ALUOP_SUB,
    ALUOP_R,
    ALUOP_I
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALWB,
    S_LUI,
    S_AUIPC,
    S_FAULT
  } state_e;

endpackage

// File: rtl/rv_multicycle_ctrl_alu_dec.sv
// ALU decoder: maps operation class plus Funct3/Funct7b5 to ALUControl.
// Ports:
//   alu_op    in  operation class (forced ADD, forced SUB, R-type, I-type)
//   funct3    in  Instr[14:12]
//   funct7b5  in  Instr[30]
//   alu_ctrl  out ALU control code
module rv_alu_dec
  import rv_ctrl_pkg::*;
(
  input  alu_op_e     alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output alu_ctrl_e   alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          // Instr[30] selects SUB only for register-register ops; for ADDI it is immediate data
          3'b000:  alu_ctrl = (alu_op == ALUOP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b011:  alu_ctrl = ALU_SLTU;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM sequencing a shared PC/IR/ALU/regfile/memory
// datapath. Memory uses a req/ready handshake guarded by a wait watchdog.
// Ports:
//   CLK, Reset                      clock (rising), async active-high reset
//   Opcode, Funct3, Funct7b5        instruction fields from the IR
//   Zero, Lt, LtU                   ALU compare flags for branches
//   MemReady                        memory completes the current request
//   MemReq, MemWrite, AdrSrc        memory port control
//   IRWrite, PCWrite, RegWrite      architectural write enables
//   ResultSrc, ALUSrcA, ALUSrcB     datapath mux selects
//   ImmSrc, ALUControl              immediate format and ALU operation
//   Fault                           sticky illegal-opcode / memory-timeout flag
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       LtU,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       Fault
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;
  logic             mem_wait;
  logic             taken;
  alu_op_e          alu_op;
  alu_ctrl_e        alu_ctrl;

  assign timeout  = (cnt_q == CNT_W'(MEM_TIMEOUT));
  assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    case (Funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = !Lt;
      3'b110:  taken = LtU;
      3'b111:  taken = !LtU;
      default: taken = 1'b0;
    endcase
  end

  // Next state and wait counter
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (MemReady)     state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: begin
        case (Opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = S_FAULT;
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (MemReady)     state_d = S_MEMWB;
        else if (timeout) state_d = S_FAULT;
      end
      S_MEMWRITE: begin
        if (MemReady)     state_d = S_FETCH;
        else if (timeout) state_d = S_FAULT;
      end
      S_MEMWB, S_ALUWB, S_BRANCH, S_JALWB:  state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI, S_AUIPC: state_d = S_ALUWB;
      S_JALR:  state_d = S_JALWB;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // Counter saturates at MEM_TIMEOUT so a late MemReady on that cycle still completes
    cnt_d = cnt_q;
    if (state_d != state_q)                 cnt_d = '0;
    else if (mem_wait && !MemReady && !timeout) cnt_d = cnt_q + CNT_W'(1);
  end

  // Datapath controls; all forced to defaults while Reset is high so an
  // in-flight request drops asynchronously without enabling any write
  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = IMM_R;
    alu_op    = ALUOP_ADD;
    Fault     = 1'b0;
    if (!Reset) begin
      case (state_q)
        S_FETCH: begin
          MemReq    = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = MemReady;
          PCWrite   = MemReady;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = IMM_B;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = (Opcode == OP_STORE) ? IMM_S : IMM_I;
        end
        S_MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = 2'b10;
          alu_op  = ALUOP_R;
        end
        S_EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = IMM_I;
          alu_op  = ALUOP_I;
        end
        S_ALUWB: RegWrite = 1'b1;
        S_BRANCH: begin
          ALUSrcA = 2'b10;
          alu_op  = ALUOP_SUB;
          PCWrite = taken;
        end
        S_JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          ImmSrc  = IMM_J;
          PCWrite = 1'b1;
        end
        S_JALR: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ImmSrc    = IMM_I;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        S_JALWB: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          RegWrite  = 1'b1;
        end
        S_LUI: begin
          ALUSrcA = 2'b11;
          ALUSrcB = 2'b01;
          ImmSrc  = IMM_U;
        end
        S_AUIPC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = IMM_U;
        end
        S_FAULT: Fault = 1'b1;
        default: Fault = 1'b1;
      endcase
    end
  end

  rv_alu_dec u_alu_dec (
    .alu_op   (alu_op),
    .funct3   (Funct3),
    .funct7b5 (Funct7b5),
    .alu_ctrl (alu_ctrl)
  );

  assign ALUControl = alu_ctrl;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Testbench for rv_multicycle_ctrl: table-driven decode vectors, directed
// multi-cycle sequences and randomized instructions checked cycle-by-cycle
// against an expected-trace model built per instruction class.
module tb_rv_multicycle_ctrl;

  localparam int unsigned MT = 16;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Funct7b5, Zero, Lt, LtU, MemReady;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Fault;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;

  rv_multicycle_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(5)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Funct3(Funct3), .Funct7b5(Funct7b5),
    .Zero(Zero), .Lt(Lt), .LtU(LtU), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  typedef logic [19:0] out_t;
  out_t act;
  assign act = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Fault};

  int total = 0;
  int bad   = 0;
  int irw_cnt, mw_cnt, rw_cnt;

  // rdy: 0 = MemReady low, 1 = MemReady high, 2 = don't care (random)
  typedef struct { out_t exp; int rdy; } cyc_t;
  cyc_t q[$];

  typedef struct {
    logic [6:0] opc; logic [2:0] f3; logic f7, z, lt, ltu;
    logic [3:0] alu; logic pcw;
  } vec_t;
  vec_t vecs[$];

  localparam logic [3:0] ALU_BASE [8] = '{4'b0000, 4'b0101, 4'b1000, 4'b1001,
                                          4'b0100, 4'b0110, 4'b0011, 4'b0010};
  localparam logic [6:0] OPS [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                      7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                      7'b0010111, 7'h7F};

  out_t FETCH_W, FETCH_R, DEC, FLT, MRD, MWR, ALUWB;

  function automatic out_t o(input logic mr, mw, adr, irw, pcw, rw,
                             input logic [1:0] res, sa, sb, input logic [2:0] imm,
                             input logic [3:0] alu, input logic f);
    return {mr, mw, adr, irw, pcw, rw, res, sa, sb, imm, alu, f};
  endfunction

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    logic [3:0] r;
    r = ALU_BASE[f3];
    if (f3 == 3'd5 && f7) r = 4'b0111;
    if (f3 == 3'd0 && f7 && is_r) r = 4'b0001;
    return r;
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic z, lt, ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void push(input out_t e, input int r);
    cyc_t c;
    c.exp = e;
    c.rdy = r;
    q.push_back(c);
  endfunction

  // n low cycles then a ready cycle; more than MT low cycles trips the watchdog
  // on the (MT+1)-th low cycle
  function automatic bit wait_phase(input out_t w, input out_t done, input int n);
    if (n > int'(MT)) begin
      for (int i = 0; i <= int'(MT); i++) push(w, 0);
      for (int i = 0; i < 3; i++) push(FLT, 2);
      return 1'b1;
    end
    for (int i = 0; i < n; i++) push(w, 0);
    push(done, 1);
    return 1'b0;
  endfunction

  function automatic bit build(input logic [6:0] opc, input logic [2:0] f3,
                               input logic f7, z, lt, ltu, input int fw, input int mw);
    q.delete();
    if (wait_phase(FETCH_W, FETCH_R, fw)) return 1'b1;
    push(DEC, 2);
    case (opc)
      7'b0000011: begin
        push(o(0,0,0,0,0,0, 2'd0,2'd2,2'd1,3'd1,4'd0,0), 2);
        if (wait_phase(MRD, MRD, mw)) return 1'b1;
        push(o(0,0,0,0,0,1, 2'd1,2'd0,2'd0,3'd0,4'd0,0), 2);
      end
      7'b0100011: begin
        push(o(0,0,0,0,0,0, 2'd0,2'd2,2'd1,3'd2,4'd0,0), 2);
        if (wait_phase(MWR, MWR, mw)) return 1'b1;
      end
      7'b0110011: begin
        push(o(0,0,0,0,0,0, 2'd0,2'd2,2'd0,3'd0,ref_alu(f3,f7,1'b1),0), 2);
        push(ALUWB, 2);
      end
      7'b0010011: begin
        push(o(0,0,0,0,0,0, 2'd0,2'd2,2'd1,3'd1,ref_alu(f3,f7,1'b0),0), 2);
        push(ALUWB, 2);
      end
      7'b1100011: push(o(0,0,0,0,ref_taken(f3,z,lt,ltu),0, 2'd0,2'd2,2'd0,3'd0,4'd1,0), 2);
      7'b1101111: begin
        push(o(0,0,0,0,1,0, 2'd0,2'd1,2'd2,3'd5,4'd0,0), 2);
        push(ALUWB, 2);
      end
      7'b1100111: begin
        push(o(0,0,0,0,1,0, 2'd2,2'd2,2'd1,3'd1,4'd0,0), 2);
        push(o(0,0,0,0,0,1, 2'd2,2'd1,2'd2,3'd0,4'd0,0), 2);
      end
      7'b0110111: begin
        push(o(0,0,0,0,0,0, 2'd0,2'd3,2'd1,3'd4,4'd0,0), 2);
        push(ALUWB, 2);
      end
      7'b0010111: begin
        push(o(0,0,0,0,0,0, 2'd0,2'd1,2'd1,3'd4,4'd0,0), 2);
        push(ALUWB, 2);
      end
      default: begin
        for (int i = 0; i < 3; i++) push(FLT, 2);
        return 1'b1;
      end
    endcase
    return 1'b0;
  endfunction

  task automatic check(input string name, input out_t got, input out_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Called shortly after a rising edge; leaves time just after a rising edge
  task automatic run(input string name, input int lim);
    for (int i = 0; i < q.size() && i < lim; i++) begin
      case (q[i].rdy)
        0:       MemReady = 1'b0;
        1:       MemReady = 1'b1;
        default: MemReady = 1'($urandom);
      endcase
      #3;
      check(name, act, q[i].exp);
      irw_cnt += int'(IRWrite);
      mw_cnt  += int'(MemWrite);
      rw_cnt  += int'(RegWrite);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    MemReady = 1'b0;
    #1;
    check("reset_outputs", act, '0);
    MemReady = 1'b1;
    #1;
    check("reset_no_enable", act, '0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    MemReady = 1'b0;
  endtask

  task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7, z, lt, ltu);
    Opcode = opc; Funct3 = f3; Funct7b5 = f7; Zero = z; Lt = lt; LtU = ltu;
  endtask

  function automatic void addv(input logic [6:0] opc, input logic [2:0] f3,
                               input logic f7, z, lt, ltu, input logic [3:0] alu, input logic pcw);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.z = z; v.lt = lt; v.ltu = ltu; v.alu = alu; v.pcw = pcw;
    vecs.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit flt;
    FETCH_W = o(1,0,0,0,0,0, 2'd2,2'd0,2'd2,3'd0,4'd0,0);
    FETCH_R = o(1,0,0,1,1,0, 2'd2,2'd0,2'd2,3'd0,4'd0,0);
    DEC     = o(0,0,0,0,0,0, 2'd0,2'd1,2'd1,3'd3,4'd0,0);
    FLT     = o(0,0,0,0,0,0, 2'd0,2'd0,2'd0,3'd0,4'd0,1);
    MRD     = o(1,0,1,0,0,0, 2'd0,2'd0,2'd0,3'd0,4'd0,0);
    MWR     = o(1,1,1,0,0,0, 2'd0,2'd0,2'd0,3'd0,4'd0,0);
    ALUWB   = o(0,0,0,0,0,1, 2'd0,2'd0,2'd0,3'd0,4'd0,0);
    irw_cnt = 0; mw_cnt = 0; rw_cnt = 0;
    set_instr(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    MemReady = 1'b0;
    #1;

    // Execute-cycle ALUControl / PCWrite, hand-derived constants
    addv(7'b0110011, 3'd0, 0, 0, 0, 0, 4'b0000, 0);  // add
    addv(7'b0110011, 3'd0, 1, 0, 0, 0, 4'b0001, 0);  // sub
    addv(7'b0110011, 3'd5, 1, 0, 0, 0, 4'b0111, 0);  // sra
    addv(7'b0110011, 3'd5, 0, 0, 0, 0, 4'b0110, 0);  // srl
    addv(7'b0110011, 3'd2, 0, 0, 0, 0, 4'b1000, 0);  // slt
    addv(7'b0110011, 3'd3, 0, 0, 0, 0, 4'b1001, 0);  // sltu
    addv(7'b0110011, 3'd7, 0, 0, 0, 0, 4'b0010, 0);  // and
    addv(7'b0110011, 3'd6, 0, 0, 0, 0, 4'b0011, 0);  // or
    addv(7'b0110011, 3'd4, 0, 0, 0, 0, 4'b0100, 0);  // xor
    addv(7'b0110011, 3'd1, 0, 0, 0, 0, 4'b0101, 0);  // sll
    addv(7'b0010011, 3'd0, 1, 0, 0, 0, 4'b0000, 0);  // addi, imm bit 30 set
    addv(7'b0010011, 3'd5, 1, 0, 0, 0, 4'b0111, 0);  // srai
    addv(7'b1100011, 3'd0, 0, 1, 0, 0, 4'b0001, 1);  // beq, Zero=1
    addv(7'b1100011, 3'd1, 0, 1, 0, 0, 4'b0001, 0);  // bne, Zero=1
    addv(7'b1100011, 3'd4, 0, 0, 1, 0, 4'b0001, 1);  // blt
    addv(7'b1100011, 3'd5, 0, 0, 1, 0, 4'b0001, 0);  // bge
    addv(7'b1100011, 3'd6, 0, 0, 0, 1, 4'b0001, 1);  // bltu
    addv(7'b1100011, 3'd7, 0, 0, 0, 0, 4'b0001, 1);  // bgeu
    addv(7'b1100011, 3'd2, 0, 1, 1, 1, 4'b0001, 0);  // reserved funct3
    foreach (vecs[k]) begin
      do_reset();
      set_instr(vecs[k].opc, vecs[k].f3, vecs[k].f7, vecs[k].z, vecs[k].lt, vecs[k].ltu);
      flt = build(vecs[k].opc, vecs[k].f3, vecs[k].f7, vecs[k].z, vecs[k].lt, vecs[k].ltu, 0, 0);
      run("tab_front", 2);
      MemReady = 1'b0;
      #3;
      check("tab_alu", out_t'(ALUControl), out_t'(vecs[k].alu));
      check("tab_pcw", out_t'(PCWrite), out_t'(vecs[k].pcw));
      @(posedge CLK);
      #1;
    end

    // addi x1,x0,5 with fetch one cycle late: single IR/PC pulse, back to FETCH
    do_reset();
    set_instr(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    flt = build(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    irw_cnt = 0;
    run("addi", 100);
    check("addi_irw_pulses", out_t'(irw_cnt), out_t'(1));
    MemReady = 1'b0;
    #3;
    check("addi_back_fetch", act, FETCH_W);
    @(posedge CLK);
    #1;

    // sw with three wait cycles: MemWrite for 4 cycles, never RegWrite
    do_reset();
    set_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    flt = build(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3);
    mw_cnt = 0; rw_cnt = 0;
    run("sw", 100);
    check("sw_memwrite_cycles", out_t'(mw_cnt), out_t'(4));
    check("sw_regwrite_cycles", out_t'(rw_cnt), out_t'(0));

    // jal, jalr, lw with boundary wait, lui, auipc chained without reset
    set_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    flt = build(7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run("jal", 100);
    set_instr(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    flt = build(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
    run("jalr", 100);
    set_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    flt = build(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, int'(MT));
    run("lw_ready_at_limit", 100);
    set_instr(7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    flt = build(7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, int'(MT), 0);
    run("lui_fetch_at_limit", 100);
    set_instr(7'b0010111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    flt = build(7'b0010111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run("auipc", 100);

    // Fetch timeout: FAULT, sticky regardless of MemReady, cleared by reset
    do_reset();
    set_instr(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    flt = build(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, int'(MT) + 1, 0);
    run("fetch_timeout", 100);
    MemReady = 1'b1;
    #3;
    check("fault_sticky", act, FLT);
    @(posedge CLK);
    #1;
    do_reset();
    #3;
    check("fault_cleared", act, FETCH_W);
    @(posedge CLK);
    #1;

    // Store timeout in MEMWRITE
    do_reset();
    set_instr(7'b0100011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    flt = build(7'b0100011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, int'(MT) + 1);
    run("store_timeout", 100);

    // Illegal opcode
    do_reset();
    set_instr(7'h7F, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    flt = build(7'h7F, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run("illegal_op", 100);

    // Reset mid-MEMWRITE: request and write drop immediately, then FETCH
    do_reset();
    set_instr(7'b0100011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    flt = build(7'b0100011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 5);
    run("sw_before_reset", 4);
    MemReady = 1'b0;
    #1;
    check("mw_in_progress", act, MWR);
    Reset = 1'b1;
    #1;
    check("mw_reset_drop", act, '0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    #1;
    check("mw_reset_refetch", act, FETCH_W);
    @(posedge CLK);
    #1;

    // Randomized instruction stream
    do_reset();
    for (int n = 0; n < 150; n++) begin
      logic [6:0] opc;
      logic [2:0] f3;
      logic f7, z, lt, ltu;
      int fw, mw;
      opc = OPS[$urandom_range(0, 9)];
      f3  = 3'($urandom);
      f7  = 1'($urandom);
      z   = 1'($urandom);
      lt  = 1'($urandom);
      ltu = 1'($urandom);
      fw  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 2));
      mw  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 2));
      set_instr(opc, f3, f7, z, lt, ltu);
      flt = build(opc, f3, f7, z, lt, ltu, fw, mw);
      run("random", 100);
      if (flt) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
